// File: rtl/priority_grant_decoder.sv
// Regenerates a registered one-hot grant from an encoded index; grant appears the cycle after acceptance.
// Defining PRIO_GNT_COUNT_EN adds gnt_cnt, a saturating count of issued grants.
module priority_grant_decoder #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  output logic [N-1:0]     gnt,
  output logic             gnt_active,
  input  logic             release_i,
  output logic             timeout,
  output logic             idx_err
`ifdef PRIO_GNT_COUNT_EN
  ,
  output logic [7:0]       gnt_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  localparam logic [IDX_W:0] N_L       = (IDX_W + 1)'(N);
  localparam logic [7:0]     HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [N-1:0]   ONE       = N'(1);

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [7:0]     hold_q, hold_d;
  logic           ready_q, ready_d;
  logic           active_q, active_d;
  logic           timeout_q, timeout_d;
  logic           idx_err_q, idx_err_d;
  logic           grant_fire;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    idx_err_d  = 1'b0;
    grant_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          if ({1'b0, req_idx} < N_L) begin
            state_d    = GRANT;
            gnt_d      = ONE << req_idx;
            hold_d     = 8'd0;
            grant_fire = 1'b1;
          end else begin
            idx_err_d = 1'b1;
          end
        end
      end
      GRANT: begin
        // Release is checked first so it wins over a coincident timeout.
        if (release_i) begin
          state_d = GAP;
          gnt_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = GAP;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    // Registered copy of the IDLE decode keeps req_ready low until the first edge after reset.
    ready_d  = (state_d == IDLE);
    active_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      hold_q    <= 8'd0;
      ready_q   <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign req_ready  = ready_q;
  assign gnt        = gnt_q;
  assign gnt_active = active_q;
  assign timeout    = timeout_q;
  assign idx_err    = idx_err_q;

`ifdef PRIO_GNT_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_fire && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gnt_cnt = cnt_q;
`else
  logic unused_grant_fire;
  assign unused_grant_fire = grant_fire;
`endif

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Randomized and directed bench for priority_grant_decoder against a cycle-count reference model.
module tb_priority_grant_decoder;

  localparam int N        = 3;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_idx;
  logic [N-1:0]     gnt;
  logic             gnt_active;
  logic             release_i;
  logic             timeout;
  logic             idx_err;
`ifdef PRIO_GNT_COUNT_EN
  logic [7:0]       gnt_cnt;
`endif

  always #5 clk = ~clk;

  priority_grant_decoder #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_idx    (req_idx),
    .gnt        (gnt),
    .gnt_active (gnt_active),
    .release_i  (release_i),
    .timeout    (timeout),
    .idx_err    (idx_err)
`ifdef PRIO_GNT_COUNT_EN
    ,
    .gnt_cnt    (gnt_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the resource, for how many cycles, and whether a dead cycle is pending.
  int m_owner;
  int m_held;
  bit m_dead;
  bit m_ready;
  bit m_to;
  bit m_err;
  int m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_dead  = 1'b0;
    m_ready = 1'b0;
    m_to    = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_clk(input logic v, input logic [IDX_W-1:0] idx, input logic rel);
    m_to  = 1'b0;
    m_err = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (rel) begin
        m_owner = -1;
        m_dead  = 1'b1;
      end else if (m_held >= MAX_HOLD) begin
        m_owner = -1;
        m_dead  = 1'b1;
        m_to    = 1'b1;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (m_ready && v) begin
      if (int'(idx) < N) begin
        m_owner = int'(idx);
        m_held  = 0;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
    m_ready = (m_owner < 0) && !m_dead;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check_val({tag, ".gnt"},        32'(gnt),        exp_gnt);
    check_val({tag, ".gnt_active"}, 32'(gnt_active), 32'(m_owner >= 0));
    check_val({tag, ".req_ready"},  32'(req_ready),  32'(m_ready));
    check_val({tag, ".timeout"},    32'(timeout),    32'(m_to));
    check_val({tag, ".idx_err"},    32'(idx_err),    32'(m_err));
`ifdef PRIO_GNT_COUNT_EN
    check_val({tag, ".gnt_cnt"},    32'(gnt_cnt),    32'(m_cnt));
`endif
  endtask

  // Called at a falling edge: check what the DUT shows now, then drive the next cycle's inputs.
  task automatic step(input string tag, input logic v, input logic [IDX_W-1:0] idx, input logic rel);
    check_outputs(tag);
    req_valid = v;
    req_idx   = idx;
    release_i = rel;
    model_clk(v, idx, rel);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_idx   = '0;
    release_i = 1'b0;
    model_reset();

    #2 rst = 1'b1;
    #1 check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    step("post_reset", 1'b0, 2'd0, 1'b0);
    step("idle", 1'b0, 2'd0, 1'b0);

    step("basic", 1'b1, 2'd2, 1'b0);
    repeat (2) step("basic", 1'b0, 2'd0, 1'b0);
    step("basic_rel", 1'b0, 2'd0, 1'b1);
    repeat (3) step("basic_gap", 1'b1, 2'd1, 1'b0);
    repeat (5) step("basic_tail", 1'b0, 2'd0, 1'b0);

    step("tmo", 1'b1, 2'd0, 1'b0);
    repeat (19) step("tmo", 1'b0, 2'd0, 1'b0);

    step("coll", 1'b1, 2'd1, 1'b0);
    repeat (14) step("coll", 1'b0, 2'd0, 1'b0);
    step("coll_rel", 1'b0, 2'd0, 1'b1);
    repeat (3) step("coll_tail", 1'b0, 2'd0, 1'b0);

    step("bad_idx", 1'b1, 2'd3, 1'b0);
    repeat (2) step("bad_idx", 1'b0, 2'd0, 1'b0);

    step("rel_idle", 1'b0, 2'd0, 1'b1);
    step("arst", 1'b1, 2'd2, 1'b0);
    step("arst", 1'b0, 2'd0, 1'b0);
    check_outputs("arst_pre");
    req_valid = 1'b0;
    release_i = 1'b0;
    rst = 1'b1;
    model_reset();
    #1 check_outputs("arst_async");
    #1 rst = 1'b0;
    model_clk(1'b0, 2'd0, 1'b0);
    @(negedge clk);
    repeat (3) step("arst_after", 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < 4500; i++) begin
      logic             v;
      logic [IDX_W-1:0] idx;
      logic             rel;
      v   = ($urandom_range(0, 3) != 0);
      idx = IDX_W'($urandom_range(0, 3));
      rel = ($urandom_range(0, 9) == 0);
      step("rand", v, idx, rel);
    end
    check_outputs("final");
`ifdef PRIO_GNT_COUNT_EN
    check_val("gnt_cnt_sat", 32'(gnt_cnt), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
